// File: rtl/prg_loader_if.sv
// Byte stream in plus myc64 ext write port out; master = loader side, slave = host/core side.
interface prg_loader_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        ext_we;
  logic [15:0] ext_addr;
  logic [7:0]  ext_data;
  logic        ext_ready;

  modport master (
    input  s_data, s_valid, s_last, ext_ready,
    output s_ready, ext_we, ext_addr, ext_data
  );

  modport slave (
    output s_data, s_valid, s_last, ext_ready,
    input  s_ready, ext_we, ext_addr, ext_data
  );
endinterface

// File: rtl/prg_loader.sv
// PRG stream loader: one held ext write per payload byte (done on ready pulse); stream stalled while a write is open.
// MYC64_PRG_LOADER_PATCH_PTRS_EN adds six zero-page pointer writes (VARTAB/ARYTAB/STREND) after the payload.
module prg_loader #(
  parameter bit          HEADER     = 1'b1,
  parameter logic [15:0] BASE_ADDR  = 16'h0801,
  parameter logic [15:0] PATCH_ADDR = 16'h002D
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  prg_loader_if.master bus,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error,
  output logic [15:0]  o_end_addr
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR_LO = 3'd1;
  localparam logic [2:0] ADDR_HI = 3'd2;
  localparam logic [2:0] FETCH   = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] FINISH  = 3'd5;
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
  localparam logic [2:0] PATCH   = 3'd6;
  localparam logic [2:0] TAIL    = PATCH;
`else
  localparam logic [2:0] TAIL    = FINISH;
`endif

  logic [2:0]  state;
  logic [15:0] addr;
  logic [15:0] ext_addr;
  logic [7:0]  ext_data;
  logic        ext_we;
  logic        last_flag;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] end_addr;
  logic        hs;
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
  logic [2:0]  patch_cnt;
  logic        in_patch;
`endif

  assign bus.s_ready  = (state == ADDR_LO) || (state == ADDR_HI) || (state == FETCH);
  assign hs           = bus.s_valid & bus.s_ready;
  assign bus.ext_we   = ext_we;
  assign bus.ext_addr = ext_addr;
  assign bus.ext_data = ext_data;
  assign o_busy       = busy;
  assign o_done       = done;
  assign o_error      = error;
  assign o_end_addr   = end_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= BASE_ADDR;
      ext_addr  <= 16'h0000;
      ext_data  <= 8'h00;
      ext_we    <= 1'b0;
      last_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      end_addr  <= 16'h0000;
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
      patch_cnt <= 3'd0;
      in_patch  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            error    <= 1'b0;
            end_addr <= 16'h0000;
            busy     <= 1'b1;
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
            patch_cnt <= 3'd0;
            in_patch  <= 1'b0;
`endif
            if (HEADER) begin
              state <= ADDR_LO;
            end else begin
              addr  <= BASE_ADDR;
              state <= FETCH;
            end
          end
        end
        ADDR_LO: begin
          if (hs) begin
            addr[7:0] <= bus.s_data;
            if (bus.s_last) begin
              // stream ended inside the header: abort without a done pulse
              error <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= ADDR_HI;
            end
          end
        end
        ADDR_HI: begin
          if (hs) begin
            addr[15:8] <= bus.s_data;
            if (bus.s_last) begin
              end_addr <= {bus.s_data, addr[7:0]};
              state    <= TAIL;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          if (hs) begin
            ext_data  <= bus.s_data;
            ext_addr  <= addr;
            last_flag <= bus.s_last;
            ext_we    <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          // addr/data registers are untouched here, so they hold until ready
          if (bus.ext_ready) begin
            ext_we <= 1'b0;
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
            if (in_patch) begin
              patch_cnt <= patch_cnt + 3'd1;
              state     <= (patch_cnt == 3'd5) ? FINISH : PATCH;
            end else
`endif
            begin
              addr <= addr + 16'd1;
              if (last_flag) begin
                end_addr <= addr + 16'd1;
                state    <= TAIL;
              end else begin
                state <= FETCH;
              end
            end
          end
        end
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
        PATCH: begin
          ext_addr <= PATCH_ADDR + {13'd0, patch_cnt};
          ext_data <= patch_cnt[0] ? end_addr[15:8] : end_addr[7:0];
          ext_we   <= 1'b1;
          in_patch <= 1'b1;
          state    <= WRITE;
        end
`endif
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboarded bench for prg_loader: a PRG-level model queues expected writes, a negedge monitor checks them.
module tb_prg_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [15:0] end_addr;

  prg_loader_if bus ();

  prg_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (start),
    .bus        (bus),
    .o_busy     (busy),
    .o_done     (done),
    .o_error    (error),
    .o_end_addr (end_addr)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  int          done_cnt = 0;
  int          wr_seen = 0;
  int          rsp_delay = 3;
  bit          rsp_spurious = 1'b0;
  logic        prev_we = 1'b0;
  logic [15:0] held_a;
  logic [7:0]  held_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every new write request, checks hold-stability after that.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_we = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (bus.ext_we) begin
        chk("s_ready_during_write", {31'd0, bus.s_ready}, 32'd0);
        if (!prev_we) begin
          wr_seen++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_write: got %h=%h, expected no write", bus.ext_addr, bus.ext_data);
          end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk("write_addr", {16'd0, bus.ext_addr}, {16'd0, e[23:8]});
            chk("write_data", {24'd0, bus.ext_data}, {24'd0, e[7:0]});
          end
          held_a = bus.ext_addr;
          held_d = bus.ext_data;
        end else begin
          chk("addr_stable", {16'd0, bus.ext_addr}, {16'd0, held_a});
          chk("data_stable", {24'd0, bus.ext_data}, {24'd0, held_d});
        end
      end
      prev_we = bus.ext_we;
    end
  end

  // Responder: one ready pulse rsp_delay cycles after a request; optional stray pulses while idle.
  initial begin
    bus.ext_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.ext_we) begin
        repeat (rsp_delay) @(negedge clk);
        bus.ext_ready = 1'b1;
        @(negedge clk);
        bus.ext_ready = 1'b0;
      end else if (rsp_spurious && !bus.ext_we && $urandom_range(3) == 0) begin
        bus.ext_ready = 1'b1;
        @(negedge clk);
        bus.ext_ready = 1'b0;
      end
    end
  end

  // Reference model: header address, one write per payload byte, 16-bit wrap, optional pointer patch.
  task automatic build_expected(input logic [7:0] s[$], output bit exp_err, output logic [15:0] exp_end);
    logic [15:0] base;
    exp_err = 1'b0;
    exp_end = 16'h0000;
    if (s.size() < 2) begin
      exp_err = 1'b1;
    end else begin
      base = {s[1], s[0]};
      for (int i = 2; i < s.size(); i++)
        exp_q.push_back({base + 16'(i - 2), s[i]});
      exp_end = base + 16'(s.size() - 2);
`ifdef MYC64_PRG_LOADER_PATCH_PTRS_EN
      for (int k = 0; k < 6; k++)
        exp_q.push_back({16'h002D + 16'(k), (k % 2 == 1) ? exp_end[15:8] : exp_end[7:0]});
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit l);
    int n = 0;
    @(negedge clk);
    bus.s_data  = b;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    start = ($urandom_range(7) == 0);
    while (!bus.s_ready && n < 1000) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    if (n >= 1000) chk("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    start = 1'b0;
    repeat ($urandom_range(2)) @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},       {31'd0, bus.ext_we},   32'd0);
    chk({tag, "_addr"},     {16'd0, bus.ext_addr}, 32'd0);
    chk({tag, "_data"},     {24'd0, bus.ext_data}, 32'd0);
    chk({tag, "_s_ready"},  {31'd0, bus.s_ready},  32'd0);
    chk({tag, "_busy"},     {31'd0, busy},         32'd0);
    chk({tag, "_done"},     {31'd0, done},         32'd0);
    chk({tag, "_error"},    {31'd0, error},        32'd0);
    chk({tag, "_end_addr"}, {16'd0, end_addr},     32'd0);
  endtask

  task automatic run_load(input logic [7:0] s[$], input int delay, input bit spur);
    bit          exp_err;
    logic [15:0] exp_end;
    int          n = 0;
    int          n_exp;
    build_expected(s, exp_err, exp_end);
    n_exp = exp_q.size();
    rsp_delay = delay;
    rsp_spurious = spur;
    done_cnt = 0;
    wr_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy",     {31'd0, busy},     32'd1);
    chk("start_error",    {31'd0, error},    32'd0);
    chk("start_end_addr", {16'd0, end_addr}, 32'd0);
    for (int i = 0; i < s.size(); i++)
      send_byte(s[i], i == s.size() - 1);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("load_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("end_error",    {31'd0, error},    {31'd0, exp_err});
    chk("end_done_cnt", done_cnt,          exp_err ? 32'd0 : 32'd1);
    chk("end_addr",     {16'd0, end_addr}, {16'd0, exp_end});
    chk("end_busy",     {31'd0, busy},     32'd0);
    chk("writes_seen",  wr_seen,           n_exp);
    chk("queue_empty",  exp_q.size(),      32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] q[$];
    int         n;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // bytes offered while idle must not be taken
    bus.s_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_s_ready", {31'd0, bus.s_ready}, 32'd0);
    end
    bus.s_valid = 1'b0;

    q = {8'h01, 8'h08, 8'hAA, 8'hBB, 8'hCC};
    run_load(q, 3, 1'b0);
    q = {8'hFE, 8'hFF, 8'h11, 8'h22, 8'h33};
    run_load(q, 0, 1'b1);
    q = {8'h00, 8'hC0};
    run_load(q, 2, 1'b0);
    q = {8'h00};
    run_load(q, 1, 1'b0);
    q = {8'h01, 8'h08, 8'hAA};
    run_load(q, 1, 1'b1);

    for (int t = 0; t < 8; t++) begin
      logic [15:0] base;
      base = (t % 2 == 0) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(3));
      q = {base[7:0], base[15:8]};
      for (int i = 0; i < int'($urandom_range(6)); i++)
        q.push_back(8'($urandom));
      run_load(q, $urandom_range(4), 1'b1);
    end

    // long stall with the next byte waiting, then reset in the middle of the write
    rsp_delay = 20;
    rsp_spurious = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back({16'h0801, 8'hAA});
    send_byte(8'h01, 1'b0);
    send_byte(8'h08, 1'b0);
    send_byte(8'hAA, 1'b0);
    bus.s_data  = 8'hBB;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.ext_we && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stall_we_seen", {31'd0, bus.ext_we}, 32'd1);
    repeat (15) @(negedge clk);
    chk("stall_we_held", {31'd0, bus.ext_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_zero("midwrite_reset");
    exp_q.delete();
    bus.s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_zero("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
